// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the shared shift-and-add multiplier scheduler.
// Holds the scheduler state enum, default widths and the round-robin picker.
package mult_share_pkg;

    localparam int M_DEF  = 8;
    localparam int N_DEF  = 8;
    localparam int R_DEF  = 4;
    localparam int MAX_R  = 32;
    localparam int MAX_RW = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // First set bit of valid, searching ptr, ptr+1, ... wrapping at r.
    // Returns -1 when no bit below r is set. ptr must be < r.
    function automatic int rr_next(
        input logic [MAX_R-1:0] valid,
        input int               ptr,
        input int               r
    );
        int idx;
        rr_next = -1;
        // Walk downwards so the smallest offset is the last one written.
        for (int k = MAX_R - 1; k >= 0; k--) begin
            if (k < r) begin
                idx = ptr + k;
                if (idx >= r) idx = idx - r;
                if (valid[MAX_RW'(idx)]) rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/shift_add_mult_core.sv
// Iterative shift-and-add multiplier datapath, one multiplier bit per clock.
// Ports: clk, rst, start (load operands), a, b, done (last bit this cycle), product.
module shift_add_mult_core #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [M+N-1:0] product
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [M+N-1:0] acc;
    logic [M+N-1:0] a_sh;
    logic [N-1:0]   b_q;
    logic [CW-1:0]  cnt;
    logic           running;

    // High on the edge that consumes the final multiplier bit.
    assign done    = running && (cnt == CW'(N - 1));
    assign product = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            a_sh    <= '0;
            b_q     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            a_sh    <= {{N{1'b0}}, a};
            b_q     <= b;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            // a_sh always equals A << cnt, so no barrel shifter is needed.
            if (b_q[cnt]) acc <= acc + a_sh;
            a_sh <= a_sh << 1;
            if (done) begin
                cnt     <= '0;
                running <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_scheduler.sv
// Round-robin scheduler sharing one shift-and-add multiplier among R requesters.
// Ports: req_valid/req_a/req_b/req_ready per requester; res_* tagged result; busy.
module mult_share_scheduler
    import mult_share_pkg::*;
#(
    parameter  int M    = M_DEF,
    parameter  int N    = N_DEF,
    parameter  int R    = R_DEF,
    localparam int ID_W = $clog2(R)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [R-1:0]      req_valid,
    input  logic [R*M-1:0]    req_a,
    input  logic [R*N-1:0]    req_b,
    output logic [R-1:0]      req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ID_W-1:0]   res_id,
    output logic [M+N-1:0]    res_product,
    output logic              busy
);

    state_t          state_q;
    state_t          state_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] grant;
    logic            any_valid;
    logic            start;
    int              pick;

    logic [M-1:0]    a_arr [R];
    logic [N-1:0]    b_arr [R];

    logic            core_done;
    logic [M+N-1:0]  core_product;

    always_comb begin
        for (int k = 0; k < R; k++) begin
            a_arr[k] = req_a[k*M +: M];
            b_arr[k] = req_b[k*N +: N];
        end
    end

    always_comb begin
        pick      = rr_next(MAX_R'(req_valid), int'(rr_ptr_q), R);
        any_valid = (pick >= 0);
        grant     = any_valid ? ID_W'(pick) : '0;
    end

    // Accept only from IDLE; the handshake edge is the start edge.
    assign start = (state_q == IDLE) && any_valid;

    always_comb begin
        req_ready = '0;
        if (start) req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (core_done) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
        end else begin
            state_q <= state_d;
            if (start) id_q <= grant;
            // Pointer moves past the owner only once its result is taken.
            if (state_q == DONE && res_ready) begin
                if (id_q == ID_W'(R - 1)) rr_ptr_q <= '0;
                else                      rr_ptr_q <= id_q + 1'b1;
            end
        end
    end

    shift_add_mult_core #(
        .M (M),
        .N (N)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_arr[grant]),
        .b       (b_arr[grant]),
        .done    (core_done),
        .product (core_product)
    );

    // The core accumulator is frozen outside BUSY, so it serves as the
    // result holding register while DONE waits on res_ready.
    assign busy        = (state_q != IDLE);
    assign res_valid   = (state_q == DONE);
    assign res_id      = res_valid ? id_q : '0;
    assign res_product = res_valid ? core_product : '0;

endmodule
